// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver:
//   - rx_state_t        : receiver FSM state encoding
//   - DEFAULT_CLKS_PER_BIT : clk cycles per serial bit (40 MHz / 9600 baud)
//   - RX_FIFO_DEPTH     : entries in the optional receive FIFO
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 4167;
    localparam int RX_FIFO_DEPTH        = 4;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Small synchronous FIFO holding received bytes. DEPTH must be a power of two
// so the read/write pointers wrap naturally.
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise the pushed word is ignored and the contents stay unchanged.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push         : write push_data
//   push_data    : word to write
//   pop          : remove the head entry
//   pop_data     : head (oldest) entry
//   empty, full  : occupancy flags
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             wr_en_s;
    logic             rd_en_s;

    assign empty    = (count_r == {(PTR_W + 1){1'b0}});
    assign full     = (count_r == DEPTH_C);
    assign pop_data = mem_r[rd_ptr_r];

    // A write into a full FIFO is only allowed when the head leaves this cycle
    assign rd_en_s = pop & ~empty;
    assign wr_en_s = push & (~full | rd_en_s);

    // Storage, pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W + 1){1'b0}};
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule : uart_rx_fifo

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// 8N1 UART receiver with mid-bit sampling and a valid/ready output port.
// Build option:
//   UART_RX_FIFO_EN defined   -> received bytes go to a 4-entry FIFO
//                                 (uart_rx_fifo); rx_data shows the oldest.
//   UART_RX_FIFO_EN undefined -> single holding register; full == rx_valid.
// Ports:
//   clk       : clock, all state changes on rising edge
//   rst_n     : asynchronous active-low reset
//   rx_i      : serial line, idle high, asynchronous to clk
//   rx_data   : byte at the output head
//   rx_valid  : rx_data holds an unread byte
//   rx_ready  : consumer accepts rx_data this cycle
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, received byte dropped because storage full
//   busy      : receiver FSM not in IDLE
// -----------------------------------------------------------------------------
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    // Half a bit period: lands the first sample in the middle of the start bit
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

    logic        sync1_r;
    logic        sync2_r;
    logic        line_prev_r;
    rx_state_t   state_r;
    rx_state_t   state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [2:0]  bit_idx_r;
    logic [2:0]  bit_idx_s;
    logic [7:0]  shift_r;
    logic [7:0]  shift_s;
    logic        push_s;
    logic        frame_err_s;
    logic        pop_s;
    logic        drop_s;
    logic        frame_err_r;
    logic        overrun_r;
    logic        busy_r;

    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;
    assign busy      = busy_r;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r     <= 1'b1;
            sync2_r     <= 1'b1;
            line_prev_r <= 1'b1;
        end else begin
            sync1_r     <= rx_i;
            sync2_r     <= sync1_r;
            line_prev_r <= sync2_r;
        end
    end

    // FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
        end
    end

    // Next-state logic: count down to zero, act on the synchronized line there
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        bit_idx_s   = bit_idx_r;
        shift_s     = shift_r;
        push_s      = 1'b0;
        frame_err_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (line_prev_r && !sync2_r) begin
                    state_s   = START;
                    cnt_s     = CNT_HALF;
                    bit_idx_s = 3'd0;
                end else begin
                    cnt_s = CNT_ZERO;
                end
            end
            START: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else if (!sync2_r) begin
                    state_s = DATA;
                    cnt_s   = CNT_FULL;
                end else begin
                    // Start bit gone by mid-bit: treat as a glitch
                    state_s = IDLE;
                end
            end
            DATA: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else begin
                    // LSB first: new bit enters at the top and shifts down
                    shift_s = {sync2_r, shift_r[7:1]};
                    cnt_s   = CNT_FULL;
                    if (bit_idx_r == 3'd7) begin
                        state_s = STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else begin
                    state_s = IDLE;
                    if (sync2_r) begin
                        push_s = 1'b1;
                    end else begin
                        frame_err_s = 1'b1;
                    end
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

`ifdef UART_RX_FIFO_EN
    logic       fifo_empty_s;
    logic       fifo_full_s;
    logic [7:0] fifo_data_s;

    assign pop_s    = rx_ready & ~fifo_empty_s;
    assign drop_s   = push_s & fifo_full_s & ~pop_s;
    assign rx_valid = ~fifo_empty_s;
    assign rx_data  = fifo_data_s;

    uart_rx_fifo #(
        .DEPTH (RX_FIFO_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (shift_r),
        .pop       (pop_s),
        .pop_data  (fifo_data_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s)
    );
`else
    logic [7:0] hold_r;
    logic       valid_r;

    assign pop_s    = rx_ready & valid_r;
    // Holding register is full exactly when it is valid and not being read
    assign drop_s   = push_s & valid_r & ~pop_s;
    assign rx_valid = valid_r;
    assign rx_data  = hold_r;

    // Single-entry holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r  <= 8'h00;
            valid_r <= 1'b0;
        end else if (push_s && !drop_s) begin
            hold_r  <= shift_r;
            valid_r <= 1'b1;
        end else if (pop_s) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end
`endif

    // Registered status pulses and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            frame_err_r <= frame_err_s;
            overrun_r   <= drop_s;
            busy_r      <= (state_s != IDLE);
        end
    end

endmodule : uart_receiver

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Randomized and directed 8N1 frames at CLKS_PER_BIT = 8. A reference model
// keeps the bytes the consumer should see in a queue (bounded by the storage
// capacity while the consumer is stalled); a monitor pops and compares on
// every rx_valid & rx_ready cycle and counts status pulses.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int CPB = 8;
`ifdef UART_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_i = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_fe   = 0;
    int exp_ov   = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    logic [7:0] model_q[$];
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_i      (rx_i),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pop on transfer, stability while stalled, pulse counts
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err === 1'b1) fe_cnt++;
            if (overrun === 1'b1) ov_cnt++;
            if (prev_hold && rx_valid === 1'b1) check("rx_data_stable", rx_data, prev_data);
            if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
                if (model_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no byte", rx_data);
                end else begin
                    check("rx_data", rx_data, model_q.pop_front());
                end
            end
            prev_hold = (rx_valid === 1'b1) && (rx_ready === 1'b0);
            prev_data = rx_data;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic drive_bit(input logic v);
        rx_i = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int nbits);
        for (int i = 0; i < nbits; i++) drive_bit(1'b1);
    endtask

    // Model: good stop -> byte expected unless storage is full with a stalled consumer
    task automatic send_frame(input logic [7:0] b, input logic stop);
        if (!stop) exp_fe++;
        else if (model_q.size() >= CAP && rx_ready == 1'b0) exp_ov++;
        else model_q.push_back(b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_frame_err"}, fe_cnt, exp_fe);
        check({tag, "_overrun"}, ov_cnt, exp_ov);
        check({tag, "_pending"}, model_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_valid"}, rx_valid, 0);
        check({tag, "_rx_data"}, rx_data, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [7:0] b;
        logic stop;
        int gap;

        #2;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Single byte, consumer always ready
        rx_ready = 1'b1;
        send_frame(8'h3D, 1'b1);
        idle(2);
        check_counts("single_3d");

        // Short low glitch: START entered then abandoned
        rx_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx_i = 1'b1;
        k = 0;
        while (busy !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        check("glitch_busy_high", busy, 1);
        k = 0;
        while (busy !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        check("glitch_back_idle", busy, 0);
        @(posedge clk);
        #1;
        idle(2);
        check_counts("glitch");

        // Bad stop bit
        send_frame(8'h55, 1'b0);
        idle(2);
        check_counts("bad_stop");

        // Overflow with a stalled consumer
        rx_ready = 1'b0;
        for (int i = 0; i <= CAP; i++) begin
            b = 8'((i + 1) * 17);
            send_frame(b, 1'b1);
        end
        idle(2);
        check("ovf_overrun", ov_cnt, exp_ov);
        check("ovf_valid_held", rx_valid, 1);
        check("ovf_head", rx_data, 8'h11);
        rx_ready = 1'b1;
        k = 0;
        while (model_q.size() != 0 && k < 50) begin @(negedge clk); k++; end
        @(posedge clk);
        #1;
        idle(1);
        check_counts("overflow");

        // Reset in the middle of bit 4
        b = 8'hA5;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx_i = b[4];
        repeat (3) @(posedge clk);
        #1;
        check("midreset_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        rx_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        send_frame(8'hA5, 1'b1);
        idle(2);
        check_counts("after_reset");

        // Back-to-back frames
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(2);
        check_counts("back_to_back");

        // Random frames, occasional bad stop, random gaps
        for (int n = 0; n < 30; n++) begin
            b = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            gap = $urandom_range(0, 2);
            if (!stop && gap == 0) gap = 1;
            send_frame(b, stop);
            idle(gap);
        end
        idle(2);
        check_counts("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_receiver
